freq_period_ctrl: RTL and testbench

//  Sequences the gate period of the frequency counter. Issues timed period_load

---
 rtl/freq_period_ctrl.sv | 140 ++++++++++++++
 tb/tb_freq_period_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/freq_period_ctrl.sv
// Gate-period sequencer: issues timed period_load pulses, arbitrates host requests and auto-range steps.
// Optional FREQ_CTRL_AUTORANGE_EN adds the auto-range engine; without it only host and reset loads occur.
module freq_period_ctrl #(
  parameter int unsigned PERIOD_W       = 12,
  parameter int unsigned COUNT_W        = 8,
  parameter int unsigned BASE_PERIOD    = 100,
  parameter int unsigned NUM_RANGES     = 4,
  parameter int unsigned DEFAULT_RANGE  = 2,
  parameter int unsigned HI_THRESH      = 90,
  parameter int unsigned LO_THRESH      = 10,
  parameter int unsigned LOAD_CYCLES    = 2,
  parameter int unsigned SETTLE_WINDOWS = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         auto_en,
  input  logic                         req_valid,
  input  logic [PERIOD_W-1:0]          req_period,
  output logic                         req_ready,
  input  logic                         count_valid,
  input  logic [COUNT_W-1:0]           count,
  output logic                         period_load,
  output logic [PERIOD_W-1:0]          period,
  output logic [$clog2(NUM_RANGES)-1:0] range_idx,
  output logic                         busy
);

  localparam int unsigned IDX_W = $clog2(NUM_RANGES);
  localparam int unsigned LC_W  = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam int unsigned SW_W  = (SETTLE_WINDOWS > 1) ? $clog2(SETTLE_WINDOWS) : 1;

  typedef enum logic [1:0] {INIT, LOAD, SETTLE, IDLE} state_t;

  // Period of an auto range, saturated to the bus width.
  function automatic logic [PERIOD_W-1:0] range_period(input logic [IDX_W-1:0] idx);
    logic [63:0] wide;
    wide = 64'(BASE_PERIOD) << idx;
    if (wide > 64'({PERIOD_W{1'b1}})) return '1;
    return PERIOD_W'(wide);
  endfunction

  localparam logic [PERIOD_W-1:0] DEFAULT_PERIOD = range_period(IDX_W'(DEFAULT_RANGE));

  state_t                state, state_n;
  logic [LC_W-1:0]       load_cnt, load_cnt_n;
  logic [SW_W-1:0]       settle_cnt, settle_cnt_n;
  logic [PERIOD_W-1:0]   period_n;
  logic [IDX_W-1:0]      idx_n;
  logic                  accept_c;

  assign accept_c = req_valid && req_ready;

`ifndef FREQ_CTRL_AUTORANGE_EN
  logic unused_auto;
  assign unused_auto = ^{auto_en, count};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= INIT;
      load_cnt    <= '0;
      settle_cnt  <= '0;
      period      <= DEFAULT_PERIOD;
      range_idx   <= IDX_W'(DEFAULT_RANGE);
      period_load <= 1'b0;
      req_ready   <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state       <= state_n;
      load_cnt    <= load_cnt_n;
      settle_cnt  <= settle_cnt_n;
      period      <= period_n;
      range_idx   <= idx_n;
      period_load <= (state_n == LOAD);
      req_ready   <= (state_n == IDLE) || (state_n == SETTLE);
      busy        <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n      = state;
    load_cnt_n   = load_cnt;
    settle_cnt_n = settle_cnt;
    period_n     = period;
    idx_n        = range_idx;
    case (state)
      INIT: begin
        state_n    = LOAD;
        load_cnt_n = '0;
        period_n   = DEFAULT_PERIOD;
        idx_n      = IDX_W'(DEFAULT_RANGE);
      end
      LOAD: begin
        if (load_cnt == LC_W'(LOAD_CYCLES - 1)) begin
          settle_cnt_n = '0;
          if (SETTLE_WINDOWS == 0) state_n = IDLE;
          else                     state_n = SETTLE;
        end else begin
          load_cnt_n = load_cnt + LC_W'(1);
        end
      end
      SETTLE: begin
        // Host may cut the settle window short; strobes here never move the range.
        if (accept_c) begin
          state_n    = LOAD;
          load_cnt_n = '0;
          period_n   = (req_period == '0) ? PERIOD_W'(1) : req_period;
        end else if (count_valid) begin
          if (settle_cnt == SW_W'(SETTLE_WINDOWS - 1)) state_n = IDLE;
          else settle_cnt_n = settle_cnt + SW_W'(1);
        end
      end
      IDLE: begin
        if (accept_c) begin
          state_n    = LOAD;
          load_cnt_n = '0;
          period_n   = (req_period == '0) ? PERIOD_W'(1) : req_period;
        end
`ifdef FREQ_CTRL_AUTORANGE_EN
        else if (auto_en && count_valid) begin
          if ((count >= COUNT_W'(HI_THRESH)) && (range_idx != '0)) begin
            idx_n      = range_idx - IDX_W'(1);
            period_n   = range_period(range_idx - IDX_W'(1));
            state_n    = LOAD;
            load_cnt_n = '0;
          end else if ((count < COUNT_W'(LO_THRESH)) &&
                       (range_idx != IDX_W'(NUM_RANGES - 1))) begin
            idx_n      = range_idx + IDX_W'(1);
            period_n   = range_period(range_idx + IDX_W'(1));
            state_n    = LOAD;
            load_cnt_n = '0;
          end
        end
`endif
      end
      default: state_n = INIT;
    endcase
  end

endmodule

// File: tb/tb_freq_period_ctrl.sv
// Directed self-checking bench for freq_period_ctrl; expectations are hand-computed constants.
module tb_freq_period_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        auto_en;
  logic        req_valid;
  logic [11:0] req_period;
  logic        req_ready;
  logic        count_valid;
  logic [7:0]  count;
  logic        period_load;
  logic [11:0] period;
  logic [1:0]  range_idx;
  logic        busy;

  int passed = 0;
  int total  = 0;

  freq_period_ctrl dut (
    .clk(clk), .reset(reset), .auto_en(auto_en),
    .req_valid(req_valid), .req_period(req_period), .req_ready(req_ready),
    .count_valid(count_valid), .count(count),
    .period_load(period_load), .period(period), .range_idx(range_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cv(input logic [7:0] c);
    count_valid = 1'b1;
    count       = c;
    step();
    count_valid = 1'b0;
  endtask

  // From the first LOAD cycle: finish the load, then close SETTLE with a neutral strobe.
  task automatic finish_load();
    step();
    step();
    pulse_cv(8'd50);
  endtask

  task automatic outs(input string tag, input logic pl, input logic [11:0] p,
                      input logic [1:0] idx, input logic rr, input logic b);
    check({tag, "_load"},  32'(period_load), 32'(pl));
    check({tag, "_period"}, 32'(period),     32'(p));
    check({tag, "_idx"},   32'(range_idx),   32'(idx));
    check({tag, "_ready"}, 32'(req_ready),   32'(rr));
    check({tag, "_busy"},  32'(busy),        32'(b));
  endtask

  task automatic host_req(input logic [11:0] p);
    req_valid  = 1'b1;
    req_period = p;
    step();
    req_valid  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; auto_en = 1'b0; req_valid = 1'b0; req_period = '0;
    count_valid = 1'b0; count = '0;
    step(); step();
    outs("reset", 1'b0, 12'd400, 2'd2, 1'b0, 1'b1);

    // 1: INIT then two load cycles, SETTLE until first strobe
    reset = 1'b0;
    step();
    outs("init_load1", 1'b1, 12'd400, 2'd2, 1'b0, 1'b1);
    step();
    outs("init_load2", 1'b1, 12'd400, 2'd2, 1'b0, 1'b1);
    step();
    outs("init_settle", 1'b0, 12'd400, 2'd2, 1'b1, 1'b1);
    pulse_cv(8'd50);
    outs("init_idle", 1'b0, 12'd400, 2'd2, 1'b1, 1'b0);

    // 2: host request
    host_req(12'd1000);
    outs("host_load1", 1'b1, 12'd1000, 2'd2, 1'b0, 1'b1);
    step();
    outs("host_load2", 1'b1, 12'd1000, 2'd2, 1'b0, 1'b1);
    step();
    outs("host_settle", 1'b0, 12'd1000, 2'd2, 1'b1, 1'b1);
    pulse_cv(8'd50);
    outs("host_idle", 1'b0, 12'd1000, 2'd2, 1'b1, 1'b0);

    auto_en = 1'b1;
`ifdef FREQ_CTRL_AUTORANGE_EN
    // 3: step down, strobe in SETTLE ignored, then step up
    pulse_cv(8'd95);
    outs("auto_dn", 1'b1, 12'd200, 2'd1, 1'b0, 1'b1);
    step(); step();
    pulse_cv(8'd95);
    outs("auto_settle_ign", 1'b0, 12'd200, 2'd1, 1'b1, 1'b0);
    pulse_cv(8'd5);
    outs("auto_up", 1'b1, 12'd400, 2'd2, 1'b0, 1'b1);
    finish_load();

    // 4: range limits
    pulse_cv(8'd95); finish_load();
    pulse_cv(8'd95); finish_load();
    outs("at_idx0", 1'b0, 12'd100, 2'd0, 1'b1, 1'b0);
    pulse_cv(8'd95);
    outs("lim_lo", 1'b0, 12'd100, 2'd0, 1'b1, 1'b0);
    pulse_cv(8'd3); finish_load();
    pulse_cv(8'd3); finish_load();
    pulse_cv(8'd3);
    outs("up_idx3", 1'b1, 12'd800, 2'd3, 1'b0, 1'b1);
    finish_load();
    pulse_cv(8'd3);
    outs("lim_hi", 1'b0, 12'd800, 2'd3, 1'b1, 1'b0);

    // 5: host wins over simultaneous strobe
    req_valid = 1'b1; req_period = 12'd300; count_valid = 1'b1; count = 8'd95;
    step();
    req_valid = 1'b0; count_valid = 1'b0;
    outs("host_wins", 1'b1, 12'd300, 2'd3, 1'b0, 1'b1);
    finish_load();
    outs("host_wins_idle", 1'b0, 12'd300, 2'd3, 1'b1, 1'b0);
    host_req(12'd0);
    outs("clamp0", 1'b1, 12'd1, 2'd3, 1'b0, 1'b1);
    finish_load();
`else
    // Auto engine absent: strobe in IDLE never loads
    pulse_cv(8'd95);
    outs("noauto_hi", 1'b0, 12'd1000, 2'd2, 1'b1, 1'b0);
    pulse_cv(8'd3);
    outs("noauto_lo", 1'b0, 12'd1000, 2'd2, 1'b1, 1'b0);

    // 5: host wins over simultaneous strobe
    req_valid = 1'b1; req_period = 12'd300; count_valid = 1'b1; count = 8'd95;
    step();
    req_valid = 1'b0; count_valid = 1'b0;
    outs("host_wins", 1'b1, 12'd300, 2'd2, 1'b0, 1'b1);
    finish_load();
    outs("host_wins_idle", 1'b0, 12'd300, 2'd2, 1'b1, 1'b0);
    host_req(12'd0);
    outs("clamp0", 1'b1, 12'd1, 2'd2, 1'b0, 1'b1);
    finish_load();
`endif
    auto_en = 1'b0;

    // 6: async reset in LOAD, then default reload
    host_req(12'd700);
    check("pre_rst_load", 32'(period_load), 32'd1);
    #1 reset = 1'b1;
    #1;
    outs("rst_in_load", 1'b0, 12'd400, 2'd2, 1'b0, 1'b1);
    step();
    reset = 1'b0;
    step();
    outs("reload1", 1'b1, 12'd400, 2'd2, 1'b0, 1'b1);
    step();
    outs("reload2", 1'b1, 12'd400, 2'd2, 1'b0, 1'b1);
    step();
    pulse_cv(8'd50);
    outs("reload_idle", 1'b0, 12'd400, 2'd2, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
